// File: rtl/regfile_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_access_pkg
// Description : Shared types for the register-file access sequencer:
//               request opcode encoding and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_access_pkg;

    // Request opcode as carried on ReqOp
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SELECT = 3'd4,
        ST_SAMPLE = 3'd5,
        ST_RESP   = 3'd6
    } state_e;

endpackage : regfile_access_pkg
`default_nettype wire

// File: rtl/regfile_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : regfile_addr_decode
// Description : Binary row index to one-hot row select. An index at or
//               beyond HEIGHT yields an all-zero select and raises o_oor.
// Ports       : i_addr   - binary row index
//               o_onehot - one-hot row select (all zero when out of range)
//               o_oor    - index is out of range
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_addr_decode #(
    parameter int HEIGHT = 3
) (
    input  logic [$clog2(HEIGHT)-1:0] i_addr,
    output logic [HEIGHT-1:0]         o_onehot,
    output logic                      o_oor
);

    localparam int ADDR_W = $clog2(HEIGHT);

    for (genvar g = 0; g < HEIGHT; g++) begin : g_row
        localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(g);
        assign o_onehot[g] = (i_addr == c_IDX);
    end

    // Compared at 32 bits so a non-power-of-two HEIGHT is handled exactly
    assign o_oor = (32'(i_addr) >= 32'(HEIGHT));

endmodule : regfile_addr_decode
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_access_ctrl
// Description : Request sequencer in front of an edge-strobed register file.
//               Accepts read / write / clear-all requests on a valid/ready
//               channel, drives one-hot row select, write data and a
//               registered write strobe with one full clock of select/data
//               setup and hold around the strobe rising edge, and returns
//               the sampled row on a response channel.
// Macro       : REGFILE_ACCESS_CLEAR_ALL_EN - when defined, op 10 zeroes
//               every row in turn; otherwise op 10 is rejected.
// Ports       : Clk, Rst_n (async, active low)
//               ReqValid/ReqReady/ReqOp/ReqAddr/ReqData - request channel
//               RespValid/RespReady/RespData/RespErr    - response channel
//               RfEn/RfCs/RfIn/RfOut                    - register file side
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl
    import regfile_access_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 3
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      ReqValid,
    output logic                      ReqReady,
    input  logic [1:0]                ReqOp,
    input  logic [$clog2(HEIGHT)-1:0] ReqAddr,
    input  logic [WIDTH-1:0]          ReqData,
    output logic                      RespValid,
    input  logic                      RespReady,
    output logic [WIDTH-1:0]          RespData,
    output logic                      RespErr,
    output logic                      RfEn,
    output logic [HEIGHT-1:0]         RfCs,
    output logic [WIDTH-1:0]          RfIn,
    input  logic [WIDTH-1:0]          RfOut
);

    localparam int ADDR_W = $clog2(HEIGHT);

    // ------------------------------------------------------------------
    // Request decode (feeds flops only; no request input reaches an Rf*
    // output without passing through a register)
    // ------------------------------------------------------------------
    logic [HEIGHT-1:0] w_dec_cs;
    logic              w_dec_oor;
    logic              w_req_err;
    logic              w_req_fire;
    op_e               w_op;

    regfile_addr_decode #(
        .HEIGHT   (HEIGHT)
    ) u_addr_decode (
        .i_addr   (ReqAddr),
        .o_onehot (w_dec_cs),
        .o_oor    (w_dec_oor)
    );

    assign w_op = op_e'(ReqOp);

    always_comb begin
        w_req_err = 1'b1;
        case (w_op)
            OP_READ,
            OP_WRITE: w_req_err = w_dec_oor;
`ifdef REGFILE_ACCESS_CLEAR_ALL_EN
            // Clear-all walks every row itself, so the address is irrelevant
            OP_CLEAR: w_req_err = 1'b0;
`endif
            default:  w_req_err = 1'b1;
        endcase
    end

    state_e            r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [WIDTH-1:0]  r_resp_data;
    logic              r_resp_err;
    logic              r_rf_en;
    logic [HEIGHT-1:0] r_rf_cs;
    logic [WIDTH-1:0]  r_rf_in;
`ifdef REGFILE_ACCESS_CLEAR_ALL_EN
    logic              r_is_clear;
    logic [ADDR_W-1:0] r_row_idx;
`endif

    // r_req_ready is only ever set on entry to IDLE, so it doubles as the
    // "in IDLE" qualifier for the handshake
    assign w_req_fire = ReqValid & r_req_ready;

    // ------------------------------------------------------------------
    // Sequencer with registered outputs. Select and data change only on
    // the IDLE->SETUP / HOLD->SETUP / HOLD->RESP transitions, never when
    // the strobe toggles (SETUP->STROBE, STROBE->HOLD).
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_rf_en      <= 1'b0;
            r_rf_cs      <= '0;
            r_rf_in      <= '0;
`ifdef REGFILE_ACCESS_CLEAR_ALL_EN
            r_is_clear   <= 1'b0;
            r_row_idx    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= '0;
                        end else if (w_op == OP_READ) begin
                            r_state <= ST_SELECT;
                            r_rf_cs <= w_dec_cs;
                        end else if (w_op == OP_WRITE) begin
                            r_state <= ST_SETUP;
                            r_rf_cs <= w_dec_cs;
                            r_rf_in <= ReqData;
`ifdef REGFILE_ACCESS_CLEAR_ALL_EN
                            r_is_clear <= 1'b0;
`endif
                        end else begin
`ifdef REGFILE_ACCESS_CLEAR_ALL_EN
                            // Clear-all: start at row 0 with zero data
                            r_state    <= ST_SETUP;
                            r_rf_cs    <= HEIGHT'(1);
                            r_rf_in    <= '0;
                            r_is_clear <= 1'b1;
                            r_row_idx  <= '0;
`else
                            // Unreachable: op 10 is decoded as an error
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
`endif
                        end
                    end
                end

                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_rf_en <= 1'b1;
                end

                ST_STROBE: begin
                    r_state <= ST_HOLD;
                    r_rf_en <= 1'b0;
                end

                ST_HOLD: begin
`ifdef REGFILE_ACCESS_CLEAR_ALL_EN
                    if (r_is_clear && (r_row_idx != ADDR_W'(HEIGHT - 1))) begin
                        r_state   <= ST_SETUP;
                        r_row_idx <= r_row_idx + 1'b1;
                        r_rf_cs   <= r_rf_cs << 1;
                    end else begin
                        r_state      <= ST_RESP;
                        r_rf_cs      <= '0;
                        r_rf_in      <= '0;
                        r_is_clear   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= '0;
                    end
`else
                    r_state      <= ST_RESP;
                    r_rf_cs      <= '0;
                    r_rf_in      <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_data  <= '0;
`endif
                end

                ST_SELECT: begin
                    // Select has been stable for a full cycle before sampling
                    r_state <= ST_SAMPLE;
                end

                ST_SAMPLE: begin
                    r_state      <= ST_RESP;
                    r_resp_data  <= RfOut;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_rf_cs      <= '0;
                end

                ST_RESP: begin
                    if (RespReady) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_data  <= '0;
                    r_resp_err   <= 1'b0;
                    r_rf_en      <= 1'b0;
                    r_rf_cs      <= '0;
                    r_rf_in      <= '0;
                end
            endcase
        end
    end

    assign ReqReady  = r_req_ready;
    assign RespValid = r_resp_valid;
    assign RespData  = r_resp_data;
    assign RespErr   = r_resp_err;
    assign RfEn      = r_rf_en;
    assign RfCs      = r_rf_cs;
    assign RfIn      = r_rf_in;

endmodule : regfile_access_ctrl
`default_nettype wire

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Synchronous sequencer that sits directly upstream of the edge-strobed register file. It accepts read, write and clear requests over a valid/ready handshake. It decodes the row address to a one-hot chip-select and generates a glitch-free, registered write strobe with guaranteed select/data setup and hold around the strobe edge. It samples the register file's selected output and returns it on a response channel.

## Interface
- `WIDTH`, 8, data width of one register row
- `HEIGHT`, 3, number of rows (≥2); `ADDR_W = $clog2(HEIGHT)` is a derived localparam
- `Clk` in 1: system clock, rising edge
- `Rst_n` in 1: reset, asynchronous, active-low
- `ReqValid` in 1: request present
- `ReqReady` out 1: controller can accept a request
- `ReqOp` in 2: 00 read, 01 write, 10 clear-all, 11 reserved
- `ReqAddr` in ADDR_W: row index
- `ReqData` in WIDTH: write data
- `RespValid` out 1: response present
- `RespReady` in 1: response consumed
- `RespData` out WIDTH: read data; 0 for write, clear and error
- `RespErr` out 1: request rejected
- `RfEn` out 1: write strobe to the register file (rising edge writes)
- `RfCs` out HEIGHT: one-hot row select
- `RfIn` out WIDTH: write data to the register file
- `RfOut` in WIDTH: register file output for the row selected by `RfCs`

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, SELECT, SAMPLE, RESP.
- IDLE:
  - `ReqReady`=1; all other outputs are 0.
  - A handshake (`ReqValid & ReqReady`) latches op, address and data.
- Write path: IDLE→SETUP→STROBE→HOLD→RESP.
  - `RfCs` and `RfIn` are driven from SETUP through HOLD.
  - `RfEn`=1 only in STROBE.
- Read path: IDLE→SELECT→SAMPLE→RESP.
  - `RfCs` is driven in SELECT and SAMPLE.
  - `RfOut` is registered into `RespData` at the end of SAMPLE.
  - `RfEn` stays 0.
- Error path:
  - Triggers: `ReqAddr` ≥ HEIGHT, op 11, or op 10 without the macro.
  - Path is IDLE→RESP with `RespErr`=1 and `RespData`=0.
  - `RfCs`, `RfEn` and `RfIn` stay 0.
- RESP:
  - `RespValid`=1; `RespData`/`RespErr` held stable until `RespReady`.
  - On the handshake, move to IDLE and clear all response outputs.
- `ReqReady`=0 in every state except IDLE. Requests are never queued.
- `RfCs` is always 0 or exactly one-hot. It never changes in the cycle `RfEn` rises or falls.
- All `Rf*` outputs are flop outputs, with no combinational path from request inputs.

## Timing
- Reset values: `ReqReady`=1, `RespValid`=0, `RespErr`=0, `RespData`=0, `RfEn`=0, `RfCs`=0, `RfIn`=0; state IDLE.
- Request accepted at edge T0:
  - Write: SETUP in T0+1, STROBE in T0+2, HOLD in T0+3, `RespValid` in T0+4. Latency is 4 cycles.
  - Read: SELECT in T0+1, SAMPLE in T0+2, `RespValid` in T0+3. Latency is 3 cycles.
  - Error: `RespValid` in T0+1.
- `RespReady` held high: the next request is accepted at the earliest 1 cycle after the RESP handshake.
- Select/data setup and hold around the `RfEn` rising edge are each ≥1 full clock.
- `Rst_n` low in any state: all outputs take their reset values immediately.
  - `RfEn` drops asynchronously.
  - An in-flight request is discarded and no response is issued.

## Configuration
- Macro `REGFILE_ACCESS_CLEAR_ALL_EN`.
- Defined: op 10 performs a clear-all.
  - The row counter `rowIdx` (0…HEIGHT-1) runs SETUP/STROBE/HOLD per row with `RfIn`=0 and `ReqAddr` ignored.
  - After HOLD of row HEIGHT-1, the FSM goes to RESP.
  - Latency is 3·HEIGHT+1 cycles.
- Undefined: op 10 takes the error path. The counter and its logic are absent.

## Structure
- `regfile_access_pkg` holds:
  - op encoding enum (`OP_READ`, `OP_WRITE`, `OP_CLEAR`, `OP_RSVD`)
  - FSM state enum
- Sub-module `regfile_addr_decode` (parameter HEIGHT): binary address → one-hot, plus an out-of-range flag.

## Test plan
- Write row 1 = 0xA5 with HEIGHT=3:
  - `RfCs`=3'b010 and `RfIn`=0xA5 from T0+1 to T0+3.
  - `RfEn`=1 only at T0+2.
  - Response at T0+4 with `RespErr`=0.
- Read row 2 with `RfOut`=0x3C while `RfCs`=3'b100 → `RespData`=0x3C, `RespValid` at T0+3, `RfEn` never high.
- `ReqAddr`=3 with HEIGHT=3 → `RespErr`=1 at T0+1; `RfCs`/`RfEn` stay 0.
- Hold `RespReady`=0 for 5 cycles after a read:
  - `RespValid`/`RespData` stay stable and `ReqReady` stays 0.
  - After `RespReady` goes high, `ReqReady` returns to 1 on the next cycle.
- `Rst_n` pulsed low during STROBE → `RfEn` falls without a clock, state IDLE, no response, `ReqReady`=1.
- With `REGFILE_ACCESS_CLEAR_ALL_EN`, op 10 → three `RfEn` pulses with `RfCs` 001, 010, 100, `RfIn`=0, response at T0+10.
